convmax_seq: RTL and testbench

- Row scheduler for the convolution/peak-search datapath (convmax).
- Accepts one camera row as a byte stream and slices it into overlapping 144-byte windows of 128 candidate positions each. Drives each window into convmax, waits its latency and merges the per-segment peaks into one absolute laser-line position per row.
- Sits between the pixel front end and the row-result consumer (Avalon/register bridge).

---
 rtl/plazer_pkg.sv | 19 +
 rtl/convmax_seq.sv | 202 ++++++++++++++++++++
 tb/tb_convmax_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plazer_pkg.sv
// Shared constants and types for the convmax row scheduler.
// Window geometry, FSM states and datapath bundle types.
package plazer_pkg;

    localparam int SEG_POS   = 128;
    localparam int WIN_BYTES = 144;
    localparam int PAD_BYTES = 16;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        WAIT,
        EMIT
    } state_t;

    typedef logic [WIN_BYTES-1:0][7:0] window_t;
    typedef logic [7:0][7:0]           kernel_t;

endpackage

// File: rtl/convmax_seq.sv
// Row scheduler: slices a pixel row into overlapping windows for convmax
// and merges the per-segment peaks into one absolute row peak.
module convmax_seq
    import plazer_pkg::*;
#(
    parameter int SEGS = 5,
    parameter int ROWS = 480,
    parameter int LAT  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sof,
    input  logic [7:0]                 pix_data,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic                       cfg_we,
    input  logic [63:0]                cfg_gauss,
    output logic [WIN_BYTES-1:0][7:0]  cv_data,
    output logic [7:0][7:0]            cv_gauss,
    output logic                       cv_start,
    input  logic [15:0]                cv_maxval,
    input  logic [7:0]                 cv_maxpos,
    input  logic                       cv_ready,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [8:0]                 res_row,
    output logic [15:0]                res_maxval,
    output logic [9:0]                 res_maxpos
);

    localparam int         ROW_W  = SEGS * SEG_POS;
    localparam logic [9:0] LAST_B = 10'(ROW_W - 1);
    localparam logic [2:0] LAST_S = 3'(SEGS - 1);
    localparam logic [8:0] LAST_R = 9'(ROWS - 1);
    localparam logic [7:0] THR0   = 8'(WIN_BYTES);
    localparam logic [7:0] THRN   = 8'(SEG_POS);
    localparam logic [3:0] LAST_P = 4'(PAD_BYTES - 1);
    localparam logic [7:0] LAT_C  = 8'(LAT);

    state_t      r_state;
    state_t      w_next;
    window_t     r_win;
    kernel_t     r_gauss;
    logic [9:0]  r_bcnt;
    logic [2:0]  r_scnt;
    logic [7:0]  r_fcnt;
    logic [3:0]  r_pcnt;
    logic [7:0]  r_wcnt;
    logic [8:0]  r_row;
    logic [15:0] r_max;
    logic [9:0]  r_pos;
    logic        r_start;

    logic        w_acc;
    logic        w_sof;
    logic        w_last;
    logic        w_fire;
    logic        w_cap;
    logic [7:0]  w_thr;
    logic [7:0]  w_fcnt_inc;
    logic [9:0]  w_seg_pos;

    // Ready is held low while reset is asserted so no byte slips in.
    assign pix_ready  = (r_state == FILL) && !reset;
    assign res_valid  = (r_state == EMIT);
    assign w_acc      = pix_valid && pix_ready;
    assign w_sof      = w_acc && sof;

    assign cv_data    = r_win;
    assign cv_gauss   = r_gauss;
    assign cv_start   = r_start;
    assign res_row    = r_row;
    assign res_maxval = r_max;
    assign res_maxpos = r_pos;

    always_comb begin
        w_thr      = (r_scnt == 3'd0) ? THR0 : THRN;
        w_fcnt_inc = r_fcnt + 8'd1;
        w_last     = w_acc && !w_sof && (r_bcnt == LAST_B);
        w_fire     = w_acc && !w_sof && !w_last && (w_fcnt_inc == w_thr);
        w_cap      = (r_state == WAIT) && (r_wcnt >= LAT_C) && cv_ready;
        w_seg_pos  = {r_scnt, 7'd0} + {2'd0, cv_maxpos};
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FILL: begin
                if (w_last) begin
                    w_next = PAD;
                end else if (w_fire) begin
                    w_next = WAIT;
                end
            end
            PAD: begin
                if (r_pcnt == LAST_P) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (w_cap) begin
                    w_next = (r_scnt == LAST_S) ? EMIT : FILL;
                end
            end
            EMIT: begin
                if (res_ready) begin
                    w_next = FILL;
                end
            end
            default: w_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win   <= '0;
            r_gauss <= '0;
            r_bcnt  <= '0;
            r_scnt  <= '0;
            r_fcnt  <= '0;
            r_pcnt  <= '0;
            r_wcnt  <= '0;
            r_row   <= '0;
            r_max   <= '0;
            r_pos   <= '0;
            r_start <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (cfg_we) begin
                r_gauss <= cfg_gauss;
            end
            unique case (r_state)
                FILL: begin
                    if (w_acc) begin
                        r_win <= {pix_data, r_win[WIN_BYTES-1:1]};
                        if (w_sof) begin
                            // sof byte becomes byte 0 of row 0
                            r_row  <= '0;
                            r_bcnt <= 10'd1;
                            r_scnt <= '0;
                            r_fcnt <= 8'd1;
                            r_max  <= '0;
                            r_pos  <= '0;
                        end else begin
                            r_bcnt <= r_bcnt + 10'd1;
                            r_fcnt <= w_fire ? 8'd0 : w_fcnt_inc;
                            r_pcnt <= '0;
                            if (w_fire) begin
                                r_start <= 1'b1;
                                r_wcnt  <= '0;
                            end
                        end
                    end
                end
                PAD: begin
                    r_win  <= {8'h00, r_win[WIN_BYTES-1:1]};
                    r_pcnt <= r_pcnt + 4'd1;
                    if (r_pcnt == LAST_P) begin
                        r_start <= 1'b1;
                        r_wcnt  <= '0;
                        r_pcnt  <= '0;
                    end
                end
                WAIT: begin
                    if (r_wcnt < LAT_C) begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                    if (w_cap) begin
                        // >= lets a later equal peak win the tie
                        if (cv_maxval >= r_max) begin
                            r_max <= cv_maxval;
                            r_pos <= w_seg_pos;
                        end
                        if (r_scnt != LAST_S) begin
                            r_scnt <= r_scnt + 3'd1;
                        end
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        r_row  <= (r_row == LAST_R) ? 9'd0 : r_row + 9'd1;
                        r_bcnt <= '0;
                        r_scnt <= '0;
                        r_fcnt <= '0;
                        r_max  <= '0;
                        r_pos  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_convmax_seq.sv
// Scoreboard bench for convmax_seq: directed rows, a convmax stand-in
// with fixed latency, and a monitor that checks each row result.
`timescale 1ns/1ps
module tb_convmax_seq;
    import plazer_pkg::*;

    localparam int SEGS  = 5;
    localparam int ROWS  = 480;
    localparam int LAT   = 2;
    localparam int ROW_W = SEGS * 128;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      sof = 1'b0;
    logic [7:0]                pix_data = '0;
    logic                      pix_valid = 1'b0;
    logic                      pix_ready;
    logic                      cfg_we = 1'b0;
    logic [63:0]               cfg_gauss = '0;
    logic [WIN_BYTES-1:0][7:0] cv_data;
    logic [7:0][7:0]           cv_gauss;
    logic                      cv_start;
    logic [15:0]               cv_maxval = 16'hFFFF;
    logic [7:0]                cv_maxpos = 8'hFF;
    logic                      cv_ready = 1'b0;
    logic                      res_valid;
    logic                      res_ready = 1'b1;
    logic [8:0]                res_row;
    logic [15:0]               res_maxval;
    logic [9:0]                res_maxpos;

    convmax_seq #(.SEGS(SEGS), .ROWS(ROWS), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .sof(sof),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .cfg_we(cfg_we), .cfg_gauss(cfg_gauss),
        .cv_data(cv_data), .cv_gauss(cv_gauss), .cv_start(cv_start),
        .cv_maxval(cv_maxval), .cv_maxpos(cv_maxpos), .cv_ready(cv_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_row(res_row), .res_maxval(res_maxval), .res_maxpos(res_maxpos)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int val;
        int pos;
        bit hold;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_t = 0;
    int   nstart = 0;
    int   base = 0;
    int   cd = 0;
    int   m_cur = 0;
    int   m_val[SEGS];
    int   m_pos[SEGS];
    int   st_val[SEGS];
    int   st_pos[SEGS];
    bit   zero_row = 1'b0;
    bit   st_zero = 1'b0;
    int   seed = 0;
    int   st_seed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic fail_to(input string nm);
        n_chk++;
        $display("FAIL %s: got timeout expected handshake", nm);
    endtask

    function automatic logic [7:0] pixf(input int b);
        if (zero_row || b >= ROW_W) return 8'h00;
        return 8'((b * 7 + 3 + seed) & 255);
    endfunction

    // convmax stand-in: result valid exactly LAT cycles after cv_start
    always @(negedge clk) begin
        cv_ready  = 1'b0;
        cv_maxval = 16'hFFFF;
        cv_maxpos = 8'hFF;
        if (reset) begin
            cd = 0;
            nstart = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0 && m_cur < SEGS) begin
                    cv_ready  = 1'b1;
                    cv_maxval = 16'(m_val[m_cur]);
                    cv_maxpos = 8'(m_pos[m_cur]);
                end
            end
            if (cv_start) begin
                m_cur = nstart - base;
                nstart++;
                cd = LAT;
                if (m_cur < SEGS)
                    check("window",
                          {cv_data[0], cv_data[71], cv_data[127], cv_data[143]},
                          {pixf(m_cur*128), pixf(m_cur*128+71),
                           pixf(m_cur*128+127), pixf(m_cur*128+143)});
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_result: got row %0d expected none",
                             res_row);
                    @(posedge clk);
                end else begin
                    e = sb.pop_front();
                    check("res_row", 64'(res_row), 64'(e.row));
                    check("res_maxval", 64'(res_maxval), 64'(e.val));
                    check("res_maxpos", 64'(res_maxpos), 64'(e.pos));
                    check("row_starts", 64'(nstart - base), 64'(SEGS));
                    check("latency", 64'(cyc - last_t), 64'(17 + LAT + 1));
                    if (e.hold) begin
                        res_ready = 1'b0;
                        for (int i = 0; i < 20; i++) begin
                            @(negedge clk);
                            check("hold",
                                  {res_valid, pix_ready, res_row, res_maxval, res_maxpos},
                                  {1'b1, 1'b0, 9'(e.row), 16'(e.val), 10'(e.pos)});
                        end
                        res_ready = 1'b1;
                    end
                    @(posedge clk);
                end
            end
        end
    end

    task automatic send_row(input int n, input bit with_sof);
        int t;
        t = 0;
        while (!pix_ready && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) begin
            fail_to("row_start");
            return;
        end
        m_val    = st_val;
        m_pos    = st_pos;
        zero_row = st_zero;
        seed     = st_seed;
        base     = nstart;
        for (int b = 0; b < n; b++) begin
            pix_data  = pixf(b);
            sof       = with_sof && (b == 0);
            pix_valid = 1'b1;
            t = 0;
            while (!pix_ready && t < 4000) begin
                @(negedge clk);
                t++;
            end
            if (!pix_ready) begin
                fail_to("pixel_accept");
                pix_valid = 1'b0;
                sof = 1'b0;
                return;
            end
            last_t = cyc;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        sof = 1'b0;
    endtask

    initial begin : stim
        int t;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_ready", 64'(pix_ready), 0);
        check("rst_cv_start", 64'(cv_start), 0);
        check("rst_res_valid", 64'(res_valid), 0);
        check("rst_cv_data", 64'(|cv_data), 0);
        check("rst_res", {res_row, res_maxval, res_maxpos}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(pix_ready), 1);
        cfg_we = 1'b1;
        cfg_gauss = 64'h8877665544332211;
        @(negedge clk);
        cfg_we = 1'b0;
        check("cv_gauss", cv_gauss, 64'h8877665544332211);

        st_zero = 1'b1; st_seed = 0;
        st_val = '{0, 0, 0, 0, 0};       st_pos = '{3, 9, 20, 40, 77};
        sb.push_back(exp_t'{0, 0, 589, 1'b0});
        send_row(ROW_W, 1'b0);

        st_zero = 1'b0; st_seed = 1;
        st_val = '{80, 100, 80, 80, 80}; st_pos = '{60, 5, 60, 60, 60};
        sb.push_back(exp_t'{1, 100, 133, 1'b0});
        send_row(ROW_W, 1'b0);

        st_seed = 2;
        st_val = '{50, 20, 20, 50, 20};  st_pos = '{10, 1, 1, 7, 1};
        sb.push_back(exp_t'{2, 50, 391, 1'b0});
        send_row(ROW_W, 1'b0);

        st_seed = 3;
        st_val = '{10, 200, 30, 200, 5}; st_pos = '{0, 127, 64, 0, 99};
        sb.push_back(exp_t'{3, 200, 384, 1'b1});
        send_row(ROW_W, 1'b0);

        st_seed = 4;
        st_val = '{300, 2, 3, 4, 5};     st_pos = '{9, 1, 1, 1, 1};
        sb.push_back(exp_t'{4, 300, 9, 1'b0});
        send_row(ROW_W, 1'b0);

        st_seed = 5;
        st_val = '{7, 7, 7, 7, 6};       st_pos = '{1, 2, 3, 4, 5};
        sb.push_back(exp_t'{5, 7, 388, 1'b0});
        send_row(ROW_W, 1'b0);

        st_seed = 6;
        st_val = '{1000, 999, 1001, 2, 3}; st_pos = '{100, 100, 0, 127, 127};
        sb.push_back(exp_t'{6, 1001, 256, 1'b0});
        send_row(ROW_W, 1'b0);

        st_seed = 7;
        st_val = '{250, 250, 250, 250, 250}; st_pos = '{1, 1, 1, 1, 1};
        send_row(300, 1'b0);

        st_seed = 8;
        st_val = '{90, 10, 10, 10, 10};  st_pos = '{3, 0, 0, 0, 0};
        sb.push_back(exp_t'{0, 90, 3, 1'b0});
        send_row(ROW_W, 1'b1);

        st_seed = 9;
        st_val = '{40, 41, 42, 43, 44};  st_pos = '{2, 2, 2, 2, 2};
        send_row(400, 1'b0);
        check("seg2_start", 64'(cv_start), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ready", 64'(pix_ready), 0);
        check("mid_rst_start", 64'(cv_start), 0);
        check("mid_rst_cv_data", 64'(|cv_data), 0);
        check("mid_rst_gauss", cv_gauss, 0);
        check("mid_rst_res", {res_valid, res_row, res_maxval, res_maxpos}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        st_seed = 10;
        st_val = '{5, 6, 7, 8, 60};      st_pos = '{1, 1, 1, 1, 70};
        sb.push_back(exp_t'{0, 60, 582, 1'b0});
        send_row(ROW_W, 1'b0);

        t = 0;
        while (sb.size() > 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) fail_to("drain");
        repeat (50) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
